seg7_to_bcd_decoder: RTL
========================

// Module: seg7_to_bcd_decoder
// PURPOSE
//  Inverse of the watch's BCD-to-7-segment path: samples a digit-multiplexed 7-seg bus
//  (ones/tens), filters glitches, decodes each stable code to a BCD nibble and emits one
//  packed two-digit BCD value plus its binary equivalent over a valid/ready handshake.
//  Used for display read-back self-check and for test loops that close on the seg7 outputs.
// PARAMETERS
//  STABLE_CNT  3  consecutive identical samples required to accept a digit (legal 1..15)
//  CNT_W       4  width of the stability counter (must hold STABLE_CNT)
// PORTS
//  clk           in   1  system clock, rising edge
//  resetN        in   1  asynchronous active-low reset
//  seg7In        in   7  segment code {g,f,e,d,c,b,a}, active high, a = bit 0
//  digitSel      in   1  digit on seg7In: 0 = ones, 1 = tens
//  sampleEn      in   1  one-cycle strobe: seg7In/digitSel valid this cycle
//  bcdOut        out  8  {tens,ones} packed BCD
//  binOut        out  7  tens*10+ones, 0..99
//  outValid      out  1  bcdOut/binOut valid, held until accepted
//  outReady      in   1  consumer accepts when outValid & outReady
//  errOut        out  1  one-cycle pulse: stable but undecodable code
// BEHAVIOUR
//  - Reset (async, resetN=0): state=S_ONES, bcdOut=0, binOut=0, outValid=0, errOut=0,
//    stability counter=0, last-code register=0, ones/tens holding nibbles=0.
//  - Legal codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex); all else illegal.
//  - Filter: applies only to sampleEn cycles whose digitSel matches the state's digit
//    (S_ONES->0, S_TENS->1); non-matching or sampleEn=0 cycles leave counter/last-code unchanged.
//    Matching sample: if seg7In==last-code, counter+1 (saturating at STABLE_CNT); otherwise
//    last-code<=seg7In, counter<=1. A digit is "stable" on the matching sample that brings
//    counter to STABLE_CNT (STABLE_CNT=1: the first matching sample).
//  - FSM:
//    S_ONES: stable legal -> ones nibble<=code, counter<=0, last-code<=0, -> S_TENS.
//    S_TENS: stable legal -> tens nibble<=code, bcdOut/binOut<=new value, -> S_OUT.
//    S_OUT : outValid=1; bcdOut/binOut frozen; all samples ignored; outReady=1 -> S_ONES
//            (counter/last-code cleared, outValid low next cycle).
//    Stable illegal in S_ONES/S_TENS: errOut=1 for exactly one cycle (registered, on the
//    edge that sees the stable sample), counter<=0, last-code<=0, state unchanged; the
//    already-captured ones nibble is kept in S_TENS.
//  - Latency: outValid rises on the edge sampling the STABLE_CNT-th tens sample; no
//    combinational path from inputs to outputs.
//  - outReady while outValid=0 has no effect. outValid never drops without outReady.
//  - binOut = tens*10 + ones computed from registered nibbles, 7 bits, no overflow (max 99).
//  - Reset mid-operation: discards captured digits; no partial value ever appears on bcdOut.
// CONFIGURATION
//  BLANK_TENS_EN defined: in S_TENS only, code 00 (all segments off, leading-zero
//    suppression) is legal and decodes to tens=0. In S_ONES 00 stays illegal.
//  BLANK_TENS_EN undefined: 00 is illegal for both digits (errOut on stable 00).
// TESTING
//  1 Reset: hold resetN=0 with toggling inputs -> bcdOut=00, binOut=0, outValid=0, errOut=0.
//  2 Nominal, STABLE_CNT=3: ones 6D x3, tens 4F x3 -> outValid=1, bcdOut=35, binOut=35;
//    hold outReady=0 5 cycles -> unchanged; outReady=1 -> outValid=0 next cycle, state S_ONES.
//  3 Glitch: ones 06,06,07,06,06,06 then tens 06 x3 -> accepted only on 6th ones sample;
//    bcdOut=11, binOut=11; interleaved digitSel=1 samples during S_ONES ignored.
//  4 Illegal: ones 7E x3 -> single errOut pulse, outValid stays 0; then ones 07 x3, tens 5B x3
//    -> bcdOut=27, binOut=27.
//  5 Blank tens: ones 07 x3, tens 00 x3 -> with BLANK_TENS_EN bcdOut=07, binOut=7;
//    without -> errOut pulse, remains S_TENS, then tens 3F x3 -> bcdOut=07.
//  6 Reset mid-op: after ones 6F accepted, pulse resetN low -> all outputs 0; tens 06 x3 alone
//    yields no outValid (state S_ONES); samples during S_OUT do not alter bcdOut.

Source files
------------

// File: rtl/seg7_to_bcd_decoder.sv
// seg7_to_bcd_decoder
//   Reads back a digit-multiplexed 7-segment bus (ones, then tens). Each
//   digit passes a stability filter and is then decoded to a BCD nibble.
//   The packed two-digit BCD value and its binary equivalent are offered
//   over a valid/ready handshake. A stable code that cannot be decoded
//   raises a one-cycle errOut pulse.
//   Optional build macro: BLANK_TENS_EN. When it is defined, an all-off
//   tens digit (code 00, leading-zero blanking) decodes to 0.
module seg7_to_bcd_decoder #(
    parameter int STABLE_CNT = 3,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [6:0] seg7In,
    input  logic       digitSel,
    input  logic       sampleEn,
    output logic [7:0] bcdOut,
    output logic [6:0] binOut,
    output logic       outValid,
    input  logic       outReady,
    output logic       errOut
);

    typedef enum logic [1:0] {
        S_ONES = 2'd0,
        S_TENS = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);

    // Returns {legal, nibble}; blankOk makes the all-off code decode to 0.
    function automatic logic [4:0] decodeSeg(input logic [6:0] code, input logic blankOk);
        logic [4:0] res;
        case (code)
            7'h3F:   res = {1'b1, 4'd0};
            7'h06:   res = {1'b1, 4'd1};
            7'h5B:   res = {1'b1, 4'd2};
            7'h4F:   res = {1'b1, 4'd3};
            7'h66:   res = {1'b1, 4'd4};
            7'h6D:   res = {1'b1, 4'd5};
            7'h7D:   res = {1'b1, 4'd6};
            7'h07:   res = {1'b1, 4'd7};
            7'h7F:   res = {1'b1, 4'd8};
            7'h6F:   res = {1'b1, 4'd9};
            7'h00:   res = blankOk ? {1'b1, 4'd0} : {1'b0, 4'd0};
            default: res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

    // tens*10 + ones, computed as tens*8 + tens*2 + ones in 7 bits (max 99).
    function automatic logic [6:0] bcdToBin(input logic [3:0] tens, input logic [3:0] ones);
        return ({3'b000, tens} << 3) + ({3'b000, tens} << 1) + {3'b000, ones};
    endfunction

    state_t           state_r, stateNext_s;
    logic [CNT_W-1:0] cnt_r, cntNext_s, filtCnt_s;
    logic [6:0]       lastCode_r, lastNext_s, filtLast_s;
    logic [3:0]       onesNib_r, onesNext_s, tensNib_r, tensNext_s;
    logic [7:0]       bcdNext_s;
    logic [6:0]       binNext_s;
    logic             validNext_s, errNext_s;
    logic             sampleHit_s, sameCode_s, stable_s, blankOk_s;
    logic [4:0]       dec_s;

`ifdef BLANK_TENS_EN
    assign blankOk_s = (state_r == S_TENS);
`else
    assign blankOk_s = 1'b0;
`endif

    assign sampleHit_s = sampleEn &&
                         (((state_r == S_ONES) && !digitSel) ||
                          ((state_r == S_TENS) &&  digitSel));
    assign sameCode_s  = (seg7In == lastCode_r);
    assign dec_s       = decodeSeg(seg7In, blankOk_s);

    // Glitch filter: count consecutive identical samples of the awaited digit.
    always_comb begin
        filtCnt_s  = cnt_r;
        filtLast_s = lastCode_r;
        stable_s   = 1'b0;
        if (sampleHit_s) begin
            if (sameCode_s) begin
                if (cnt_r != STABLE_C) begin
                    filtCnt_s = cnt_r + ONE_C;
                end else begin
                    filtCnt_s = cnt_r;
                end
            end else begin
                filtLast_s = seg7In;
                filtCnt_s  = ONE_C;
            end
            // Stable only on the sample that reaches the threshold, not while saturated.
            stable_s = (filtCnt_s == STABLE_C) && !(sameCode_s && (cnt_r == STABLE_C));
        end else begin
            stable_s = 1'b0;
        end
    end

    // Next-state and next-output logic for the capture / handshake FSM.
    always_comb begin
        stateNext_s = state_r;
        cntNext_s   = filtCnt_s;
        lastNext_s  = filtLast_s;
        onesNext_s  = onesNib_r;
        tensNext_s  = tensNib_r;
        bcdNext_s   = bcdOut;
        binNext_s   = binOut;
        validNext_s = 1'b0;
        errNext_s   = 1'b0;
        case (state_r)
            S_ONES: begin
                if (stable_s) begin
                    cntNext_s  = ZERO_C;
                    lastNext_s = 7'h00;
                    if (dec_s[4]) begin
                        onesNext_s  = dec_s[3:0];
                        stateNext_s = S_TENS;
                    end else begin
                        errNext_s = 1'b1;
                    end
                end else begin
                    stateNext_s = S_ONES;
                end
            end
            S_TENS: begin
                if (stable_s) begin
                    cntNext_s  = ZERO_C;
                    lastNext_s = 7'h00;
                    if (dec_s[4]) begin
                        tensNext_s  = dec_s[3:0];
                        bcdNext_s   = {dec_s[3:0], onesNib_r};
                        binNext_s   = bcdToBin(dec_s[3:0], onesNib_r);
                        validNext_s = 1'b1;
                        stateNext_s = S_OUT;
                    end else begin
                        errNext_s = 1'b1;
                    end
                end else begin
                    stateNext_s = S_TENS;
                end
            end
            S_OUT: begin
                if (outReady) begin
                    validNext_s = 1'b0;
                    cntNext_s   = ZERO_C;
                    lastNext_s  = 7'h00;
                    stateNext_s = S_ONES;
                end else begin
                    validNext_s = 1'b1;
                end
            end
            default: begin
                cntNext_s   = ZERO_C;
                lastNext_s  = 7'h00;
                stateNext_s = S_ONES;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r <= S_ONES;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Filter, digit holding and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_r      <= ZERO_C;
            lastCode_r <= 7'h00;
            onesNib_r  <= 4'd0;
            tensNib_r  <= 4'd0;
            bcdOut     <= 8'h00;
            binOut     <= 7'd0;
            outValid   <= 1'b0;
            errOut     <= 1'b0;
        end else begin
            cnt_r      <= cntNext_s;
            lastCode_r <= lastNext_s;
            onesNib_r  <= onesNext_s;
            tensNib_r  <= tensNext_s;
            bcdOut     <= bcdNext_s;
            binOut     <= binNext_s;
            outValid   <= validNext_s;
            errOut     <= errNext_s;
        end
    end

endmodule
